// File: rtl/md_iter_unit.sv
// ---------------------------------------------------------------------------
// md_iter_unit
//   Multiply/divide unit for the EX stage. Owns the architectural HI/LO pair.
//   Multiplies (mult, multu, madd, maddu, msub, msubu) take MULT_LAT cycles
//   from the accept edge to the HI/LO commit. Divides (div, divu) use an
//   iterative radix-2 restoring divider. It produces one quotient bit per
//   cycle for WIDTH cycles, then spends one cycle fixing signs before commit.
//   A divide by zero still runs the full latency. It then commits
//   LO = all ones and HI = a, and raises the sticky div_by_zero flag.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; clears HI/LO, flags and the FSM
//   clr          synchronous flush; aborts an in-flight op, keeps HI/LO/flag
//   start        launch op on this edge (ignored while busy or flushing)
//   op[3:0]      0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6 mfhi,7 mflo,
//                8 madd,9 maddu,10 msub,11 msubu, 12-15 no-op
//   a, b         rs / rt operands
//   hl           HI when op==6, LO when op==7, else zero (combinational)
//   busy         operation in flight (drives the decode stall)
//   div_by_zero  last divide had b==0; cleared by the next accepted real op
// ---------------------------------------------------------------------------
module md_iter_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hl,
    output logic             busy,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    // One counter serves both the multiply latency and the divide bit count.
    localparam int CNT_MAX = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               dbz_r;
    logic [3:0]         op_r;
    // Multiply: both operands. Divide: opa_r = raw dividend, opb_r = |divisor|.
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;   // holds |dividend| and shifts in quotient bits
    logic               neg_q_r;
    logic               neg_r_r;
    logic               bzero_r;

    logic               accept_s;
    logic               mul_signed_s;
    logic               mul_add_s;
    logic               mul_sub_s;
    logic [2*WIDTH-1:0] mul_a_ext_s;
    logic [2*WIDTH-1:0] mul_b_ext_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] mul_res_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [WIDTH:0]     shift_s;
    logic               ge_s;
    logic [WIDTH-1:0]   rem_nxt_s;
    logic [WIDTH-1:0]   quo_nxt_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;

    // A start counts only when idle and neither reset nor flush is active.
    assign accept_s = start & ~busy_r & ~clr & ~reset;

    assign busy        = busy_r;
    assign div_by_zero = dbz_r;

    // Read port: only committed HI/LO are ever visible.
    always_comb begin
        hl = {WIDTH{1'b0}};
        case (op)
            OP_MFHI: hl = hi_r;
            OP_MFLO: hl = lo_r;
            default: hl = {WIDTH{1'b0}};
        endcase
    end

    // Decode the latched multiply flavour: signedness and accumulate direction.
    always_comb begin
        mul_signed_s = 1'b0;
        mul_add_s    = 1'b0;
        mul_sub_s    = 1'b0;
        case (op_r)
            OP_MULT:  mul_signed_s = 1'b1;
            OP_MULTU: mul_signed_s = 1'b0;
            OP_MADD:  begin mul_signed_s = 1'b1; mul_add_s = 1'b1; end
            OP_MADDU: mul_add_s = 1'b1;
            OP_MSUB:  begin mul_signed_s = 1'b1; mul_sub_s = 1'b1; end
            OP_MSUBU: mul_sub_s = 1'b1;
            default:  mul_signed_s = 1'b0;
        endcase
    end

    // Product from the latched operands. The operands are held steady for the
    // whole MULT_LAT window, so this path has that many cycles to settle. The
    // accumulate reads HI/LO as they stand at the commit edge.
    always_comb begin
        mul_a_ext_s = mul_signed_s ? {{WIDTH{opa_r[WIDTH-1]}}, opa_r}
                                   : {{WIDTH{1'b0}}, opa_r};
        mul_b_ext_s = mul_signed_s ? {{WIDTH{opb_r[WIDTH-1]}}, opb_r}
                                   : {{WIDTH{1'b0}}, opb_r};
        prod_s      = mul_a_ext_s * mul_b_ext_s;
        if (mul_add_s) begin
            mul_res_s = {hi_r, lo_r} + prod_s;
        end else if (mul_sub_s) begin
            mul_res_s = {hi_r, lo_r} - prod_s;
        end else begin
            mul_res_s = prod_s;
        end
    end

    // Operand magnitudes for a signed divide, taken at the accept edge.
    always_comb begin
        a_neg_s = (op == OP_DIV) & a[WIDTH-1];
        b_neg_s = (op == OP_DIV) & b[WIDTH-1];
        if (a_neg_s) begin
            a_abs_s = {WIDTH{1'b0}} - a;
        end else begin
            a_abs_s = a;
        end
        if (b_neg_s) begin
            b_abs_s = {WIDTH{1'b0}} - b;
        end else begin
            b_abs_s = b;
        end
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value is below 2*divisor and the difference fits WIDTH bits.
    always_comb begin
        shift_s   = {rem_r, quo_r[WIDTH-1]};
        ge_s      = (shift_s >= {1'b0, opb_r});
        if (ge_s) begin
            rem_nxt_s = shift_s[WIDTH-1:0] - opb_r;
        end else begin
            rem_nxt_s = shift_s[WIDTH-1:0];
        end
        quo_nxt_s = {quo_r[WIDTH-2:0], ge_s};
    end

    // Sign fix-up. The quotient takes the xor of the signs and the remainder
    // follows the dividend. The most-negative / -1 case falls out naturally:
    // the magnitude 2^(WIDTH-1) is not negated.
    always_comb begin
        if (neg_q_r) begin
            q_fix_s = {WIDTH{1'b0}} - quo_r;
        end else begin
            q_fix_s = quo_r;
        end
        if (neg_r_r) begin
            r_fix_s = {WIDTH{1'b0}} - rem_r;
        end else begin
            r_fix_s = rem_r;
        end
    end

    // Control FSM plus HI/LO and divider state; all outputs come from registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            dbz_r   <= 1'b0;
            op_r    <= 4'd0;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            bzero_r <= 1'b0;
        end else if (clr) begin
            // Flush: abandon any in-flight op without committing.
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                op_r    <= op;
                                opa_r   <= a;
                                opb_r   <= b;
                                cnt_r   <= CW'(MULT_LAT);
                                state_r <= ST_MUL;
                                busy_r  <= 1'b1;
                                dbz_r   <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_r    <= op;
                                opa_r   <= a;
                                opb_r   <= b_abs_s;
                                quo_r   <= a_abs_s;
                                rem_r   <= {WIDTH{1'b0}};
                                neg_q_r <= a_neg_s ^ b_neg_s;
                                neg_r_r <= a_neg_s;
                                bzero_r <= (b == {WIDTH{1'b0}});
                                cnt_r   <= CW'(WIDTH);
                                state_r <= ST_DIV;
                                busy_r  <= 1'b1;
                                dbz_r   <= 1'b0;
                            end
                            OP_MTHI: begin
                                hi_r  <= a;
                                dbz_r <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo_r  <= a;
                                dbz_r <= 1'b0;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_r == CW'(1)) begin
                        {hi_r, lo_r} <= mul_res_s;
                        cnt_r        <= {CW{1'b0}};
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    if (cnt_r == CW'(1)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_FIX: begin
                    if (bzero_r) begin
                        lo_r  <= {WIDTH{1'b1}};
                        hi_r  <= opa_r;
                        dbz_r <= 1'b1;
                    end else begin
                        lo_r <= q_fix_s;
                        hi_r <= r_fix_s;
                    end
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_md_iter_unit
//   Scoreboard bench for md_iter_unit (WIDTH=32, MULT_LAT=5).
//   The stimulus pushes expected HI/LO/flag readbacks and expected busy-run
//   lengths into queues. A negedge monitor pops them and compares them with
//   what the DUT shows. The reference model uses plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_md_iter_unit;

    localparam int W = 32;
    localparam int MULT_LAT = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  hl;
    logic          busy;
    logic          div_by_zero;

    md_iter_unit #(.WIDTH(W), .MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .reset(reset), .clr(clr), .start(start), .op(op),
        .a(a), .b(b), .hl(hl), .busy(busy), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp_hl;
        logic        exp_dbz;
        bit          chk_dbz;
        string       name;
    } obs_t;

    obs_t        obs_q[$];
    int          lat_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          obs_en = 1'b0;

    // reference model state
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;
    logic        dbz_m = 1'b0;

    // ------------------------------------------------------------------ monitor
    obs_t mon_e;
    int   mon_run = 0;
    int   mon_exp;
    always @(negedge clk) begin
        if (obs_en) begin
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL obs_underflow: DUT output sampled with no expectation queued");
            end else begin
                mon_e = obs_q.pop_front();
                if (hl !== mon_e.exp_hl) begin
                    errors++;
                    $display("FAIL %s hl: got %h expected %h", mon_e.name, hl, mon_e.exp_hl);
                end
                if (mon_e.chk_dbz) begin
                    checks++;
                    if (div_by_zero !== mon_e.exp_dbz) begin
                        errors++;
                        $display("FAIL %s div_by_zero: got %b expected %b",
                                 mon_e.name, div_by_zero, mon_e.exp_dbz);
                    end
                end
            end
        end
        if (busy === 1'b1) begin
            mon_run++;
        end else if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL busy_x: got %b expected 0 or 1", busy);
        end else if (mon_run > 0) begin
            checks++;
            if (lat_q.size() == 0) begin
                errors++;
                $display("FAIL busy_len: got run of %0d cycles expected none", mon_run);
            end else begin
                mon_exp = lat_q.pop_front();
                if (mon_run != mon_exp) begin
                    errors++;
                    $display("FAIL busy_len: got %0d cycles expected %0d", mon_run, mon_exp);
                end
            end
            mon_run = 0;
        end
    end

    // ------------------------------------------------------------------ model
    function automatic int lat_of(input logic [3:0] o);
        case (o)
            4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11: return MULT_LAT;
            4'd2, 4'd3:                           return W + 1;
            default:                              return 0;
        endcase
    endfunction

    task automatic model_commit(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [63:0] acc;
        int          ix;
        int          iy;
        acc = {hi_m, lo_m};
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        if (o == 4'd0 || o == 4'd8 || o == 4'd10) begin
            p = sx * sy;
        end else begin
            p = {32'd0, x} * {32'd0, y};
        end
        case (o)
            4'd0, 4'd1: begin {hi_m, lo_m} = p; dbz_m = 1'b0; end
            4'd8, 4'd9: begin {hi_m, lo_m} = acc + p; dbz_m = 1'b0; end
            4'd10, 4'd11: begin {hi_m, lo_m} = acc - p; dbz_m = 1'b0; end
            4'd2: begin
                ix = $signed(x);
                iy = $signed(y);
                if (y == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = x; dbz_m = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000; hi_m = 32'd0; dbz_m = 1'b0;
                end else begin
                    lo_m = ix / iy; hi_m = ix % iy; dbz_m = 1'b0;
                end
            end
            4'd3: begin
                if (y == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = x; dbz_m = 1'b1;
                end else begin
                    lo_m = x / y; hi_m = x % y; dbz_m = 1'b0;
                end
            end
            4'd4: begin hi_m = x; dbz_m = 1'b0; end
            4'd5: begin lo_m = x; dbz_m = 1'b0; end
            default: begin end
        endcase
    endtask

    // ------------------------------------------------------------------ stimulus
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s timeout: busy got %b expected 0 within 200 cycles", name, busy);
        end
    endtask

    // Issue one op. abort_after > 0 flushes with clr once busy has been high
    // for that many cycles.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int abort_after);
        int lat;
        start = 1'b1; op = o; a = x; b = y;
        cyc();
        start = 1'b0; op = 4'd12; a = $urandom; b = $urandom;
        lat = lat_of(o);
        if (lat > 0 && abort_after > 0) begin
            lat_q.push_back(abort_after);
            repeat (abort_after - 1) cyc();
            clr = 1'b1;
            cyc();
            clr = 1'b0;
            dbz_m = 1'b0;
        end else if (lat > 0) begin
            lat_q.push_back(lat);
            wait_idle("op_done");
            model_commit(o, x, y);
        end else begin
            model_commit(o, x, y);
        end
    endtask

    // Read HI then LO (with the flag) using accepted mfhi/mflo starts.
    task automatic readback(input logic [31:0] eh, input logic [31:0] el,
                            input logic ed, input string name);
        obs_t e;
        start = 1'b1; op = 4'd6; obs_en = 1'b1;
        e.exp_hl = eh; e.exp_dbz = 1'b0; e.chk_dbz = 1'b0; e.name = {name, "_hi"};
        obs_q.push_back(e);
        cyc();
        op = 4'd7;
        e.exp_hl = el; e.exp_dbz = ed; e.chk_dbz = 1'b1; e.name = {name, "_lo"};
        obs_q.push_back(e);
        cyc();
        obs_en = 1'b0; start = 1'b0; op = 4'd12;
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        reset = 1'b1; clr = 1'b0; start = 1'b0; op = 4'd12; a = 32'd0; b = 32'd0;
        repeat (3) cyc();
        reset = 1'b0;
        readback(32'd0, 32'd0, 1'b0, "reset");

        do_op(4'd0, 32'hFFFF_FFFD, 32'd5, 0);
        readback(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult");
        do_op(4'd1, 32'hFFFF_FFFF, 32'd2, 0);
        readback(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu");
        do_op(4'd2, 32'hFFFF_FFF9, 32'd2, 0);
        readback(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div");
        do_op(4'd3, 32'd7, 32'd0, 0);
        readback(32'd7, 32'hFFFF_FFFF, 1'b1, "divu_zero");
        readback(32'd7, 32'hFFFF_FFFF, 1'b1, "dbz_sticky");
        do_op(4'd4, 32'h10, 32'd0, 0);
        do_op(4'd5, 32'h20, 32'd0, 0);
        do_op(4'd8, 32'd3, 32'd4, 0);
        readback(32'h10, 32'h2C, 1'b0, "madd");
        do_op(4'd11, 32'h30, 32'd1, 0);
        readback(32'hF, 32'hFFFF_FFFC, 1'b0, "msubu");
        do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        readback(32'd0, 32'h8000_0000, 1'b0, "div_ovf");
        do_op(4'd2, 32'hFFFF_FFF9, 32'd0, 0);
        readback(32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_zero_s");

        // mthi while a divu is in flight must be ignored
        start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
        cyc();
        start = 1'b0; op = 4'd12;
        lat_q.push_back(W + 1);
        repeat (2) cyc();
        start = 1'b1; op = 4'd4; a = 32'hDEAD_BEEF;
        cyc();
        start = 1'b0; op = 4'd12;
        wait_idle("busy_ign");
        model_commit(4'd3, 32'd100, 32'd7);
        readback(32'd2, 32'd14, 1'b0, "busy_ign");

        // flush a divu after 10 busy cycles: no commit
        do_op(4'd3, 32'd7, 32'd0, 0);
        do_op(4'd3, 32'd1000, 32'd3, 10);
        readback(32'd7, 32'hFFFF_FFFF, 1'b0, "clr_abort");

        // start on the same edge as clr is dropped
        start = 1'b1; op = 4'd4; a = 32'h1234; clr = 1'b1;
        cyc();
        start = 1'b0; op = 4'd12; clr = 1'b0;
        readback(32'd7, 32'hFFFF_FFFF, 1'b0, "clr_start");

        // reset in the middle of a mult
        start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd3;
        cyc();
        start = 1'b0; op = 4'd12;
        lat_q.push_back(2);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0; dbz_m = 1'b0;
        readback(32'd0, 32'd0, 1'b0, "reset_mid");

        // randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 9));
                2: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry, 0);
            readback(hi_m, lo_m, dbz_m, "rand");
        end

        repeat (3) cyc();
        checks++;
        if (lat_q.size() != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d busy and %0d readback entries left expected 0 and 0",
                     lat_q.size(), obs_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
